// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Brief    : Shared pipeline constants: MDU latencies, tracker state encoding,
//            reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  localparam int          BUSY_CNT_W  = 4;
  localparam logic [3:0]  MULT_CYCLES = 4'd5;
  localparam logic [3:0]  DIV_CYCLES  = 4'd10;
  localparam logic [31:0] RESET_PC    = 32'h0000_3000;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_t;

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/mdu_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mdu_busy_tracker
// Brief    : Tracks an in-flight mult/div and raises busy for its latency.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_busy_tracker
  import fetch_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mdu_start,
  input  logic mdu_is_div,
  output logic mdu_busy
);

  mdu_state_t            r_state;
  logic [BUSY_CNT_W-1:0] r_busy_cnt;
  logic                  r_busy;
  logic [BUSY_CNT_W-1:0] w_load;

  assign w_load   = mdu_is_div ? DIV_CYCLES : MULT_CYCLES;
  assign mdu_busy = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_busy_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (mdu_start) begin
            r_busy_cnt <= w_load;
            r_state    <= MDU_WAIT;
            r_busy     <= 1'b1;
          end
        end
        MDU_WAIT: begin
          // A start here means the stall logic let one through; restart the count.
          if (mdu_start) begin
            r_busy_cnt <= w_load;
          end else if (r_busy_cnt == 4'd1) begin
            r_busy_cnt <= '0;
            r_state    <= RUN;
            r_busy     <= 1'b0;
          end else begin
            r_busy_cnt <= r_busy_cnt - 4'd1;
          end
        end
        default: begin
          r_busy_cnt <= '0;
          r_state    <= RUN;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule : mdu_busy_tracker
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Next-PC selection and stall/flush control for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic        D_BranchTaken,
  input  logic [31:0] D_BranchTarget,
  input  logic        D_Jump,
  input  logic [31:0] D_JumpTarget,
  input  logic        H_Stall,
  input  logic        E_MDUStart,
  input  logic        E_MDUIsDiv,
  input  logic        D_MDUUse,
  output logic [31:0] Npc,
  output logic        PC_RegWE,
  output logic        D_RegWE,
  output logic        E_Flush,
  output logic        MDU_Busy
);

  logic w_mdu_busy;
  logic w_mdu_stall;
  logic w_stall;

  mdu_busy_tracker u_mdu_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .mdu_start  (E_MDUStart),
    .mdu_is_div (E_MDUIsDiv),
    .mdu_busy   (w_mdu_busy)
  );

  assign w_mdu_stall = D_MDUUse & (E_MDUStart | w_mdu_busy);
  assign w_stall     = H_Stall | w_mdu_stall;

  assign MDU_Busy = w_mdu_busy;
  assign PC_RegWE = ~w_stall;
  assign D_RegWE  = ~w_stall;
  assign E_Flush  = w_stall;

  // Redirects are ignored while stalled; the delay slot in F is never squashed.
  always_comb begin
    Npc = F_PC + 32'd4;
    if (!w_stall && D_Jump) begin
      Npc = D_JumpTarget;
    end else if (!w_stall && D_BranchTaken) begin
      Npc = D_BranchTarget;
    end
  end

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Scoreboard bench for fetch_sequencer redirect, stall and MDU timing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_PC;
  logic        D_BranchTaken;
  logic [31:0] D_BranchTarget;
  logic        D_Jump;
  logic [31:0] D_JumpTarget;
  logic        H_Stall;
  logic        E_MDUStart;
  logic        E_MDUIsDiv;
  logic        D_MDUUse;
  logic [31:0] Npc;
  logic        PC_RegWE;
  logic        D_RegWE;
  logic        E_Flush;
  logic        MDU_Busy;

  typedef struct {
    int          id;
    logic [31:0] npc;
    logic        pc_we;
    logic        d_we;
    logic        flush;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   step_id = 0;
  int   m_rem   = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .F_PC           (F_PC),
    .D_BranchTaken  (D_BranchTaken),
    .D_BranchTarget (D_BranchTarget),
    .D_Jump         (D_Jump),
    .D_JumpTarget   (D_JumpTarget),
    .H_Stall        (H_Stall),
    .E_MDUStart     (E_MDUStart),
    .E_MDUIsDiv     (E_MDUIsDiv),
    .D_MDUUse       (D_MDUUse),
    .Npc            (Npc),
    .PC_RegWE       (PC_RegWE),
    .D_RegWE        (D_RegWE),
    .E_Flush        (E_Flush),
    .MDU_Busy       (MDU_Busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input logic [31:0] pc, input logic bt, input logic [31:0] btgt,
                      input logic j, input logic [31:0] jtgt, input logic hs,
                      input logic start, input logic isdiv, input logic use_mdu);
    exp_t e;
    logic stall;
    @(posedge clk);
    #1;
    F_PC = pc; D_BranchTaken = bt; D_BranchTarget = btgt; D_Jump = j;
    D_JumpTarget = jtgt; H_Stall = hs; E_MDUStart = start; E_MDUIsDiv = isdiv;
    D_MDUUse = use_mdu;
    stall   = hs | (use_mdu & (start | (m_rem != 0)));
    e.id    = step_id;
    e.busy  = (m_rem != 0);
    e.pc_we = ~stall;
    e.d_we  = ~stall;
    e.flush = stall;
    e.npc   = (!stall && j) ? jtgt : (!stall && bt) ? btgt : pc + 32'd4;
    sb_q.push_back(e);
    step_id++;
    if (start && m_rem == 0) m_rem = isdiv ? 10 : 5;
    else if (m_rem > 0)      m_rem--;
  endtask

  task automatic idle(input logic [31:0] pc, input logic use_mdu);
    step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, use_mdu);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_value($sformatf("npc@%0d", e.id),   Npc,      e.npc);
      check_value($sformatf("pcwe@%0d", e.id),  {31'b0, PC_RegWE}, {31'b0, e.pc_we});
      check_value($sformatf("dwe@%0d", e.id),   {31'b0, D_RegWE},  {31'b0, e.d_we});
      check_value($sformatf("flush@%0d", e.id), {31'b0, E_Flush},  {31'b0, e.flush});
      check_value($sformatf("busy@%0d", e.id),  {31'b0, MDU_Busy}, {31'b0, e.busy});
    end
    // A start while busy would mean the stall logic let a second MDU op through.
    if (!reset && E_MDUStart && MDU_Busy) begin
      n_total++;
      n_bad++;
      $display("FAIL start_in_busy: got start=1 busy=1 want no overlap");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    F_PC = 32'h0; D_BranchTaken = 1'b0; D_BranchTarget = 32'h0; D_Jump = 1'b0;
    D_JumpTarget = 32'h0; H_Stall = 1'b0; E_MDUStart = 1'b0; E_MDUIsDiv = 1'b0;
    D_MDUUse = 1'b1;
    #2;
    check_value("rst_busy", {31'b0, MDU_Busy}, 32'd0);
    check_value("rst_pcwe", {31'b0, PC_RegWE}, 32'd1);
    check_value("rst_npc",  Npc, 32'd4);
    @(posedge clk); #1;
    reset = 1'b0;
    m_rem = 0;

    // Sequential fetch from the reset PC.
    for (int i = 0; i < 3; i++) idle(32'h0000_3000, 1'b0);
    // Redirects: branch, jump over branch, jump alone.
    step(32'h3008, 1'b1, 32'h3040, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h3008, 1'b1, 32'h3040, 1'b1, 32'h3100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h300c, 1'b0, 32'h0,    1'b1, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b0);
    // Stalled redirects must not be taken.
    step(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h3010, 1'b1, 32'h3040, 1'b1, 32'h3100, 1'b1, 1'b0, 1'b0, 1'b0);
    // PC wraparound.
    idle(32'hFFFF_FFFC, 1'b0);

    // Mult with HI/LO user in D: start cycle plus 5 stalled, then free.
    step(32'h3020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) idle(32'h3024, 1'b1);
    // Mult with no MDU user: busy but no stall; redirect still taken.
    step(32'h3030, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(32'h3034, 1'b1, 32'h3080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(32'h3038, 1'b0);
    // Full divide.
    step(32'h3040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) idle(32'h3044, (i % 2) == 1);
    // Divide aborted by reset at busy cycle 4.
    step(32'h3050, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(32'h3054, 1'b0);
    @(negedge clk); #2;
    check_value("pre_rst_busy", {31'b0, MDU_Busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_value("async_rst_busy", {31'b0, MDU_Busy}, 32'd0);
    m_rem = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle(32'h3000, 1'b1);

    @(posedge clk);
    @(posedge clk);
    check_value("sb_drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
